// File: rtl/core_pipe_pkg.sv
// Shared pipeline payload types, invalid constants and sizing helpers.
package core_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 8;

    // Fill values used by stages to build their per-stage INV_DATA.
    localparam logic [XLEN-1:0] DATA_INVALID = '0;
    localparam logic [XLEN-1:0] ADDR_INVALID = '0;
    localparam logic [OP_W-1:0] OP_INVALID   = '0;

    // IF/ID payload.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } id_payload_t;

    // ID/EX payload.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
    } ex_payload_t;

    localparam int unsigned ID_PAYLOAD_W = $bits(id_payload_t);
    localparam int unsigned EX_PAYLOAD_W = $bits(ex_payload_t);

    localparam id_payload_t ID_INVALID = '{pc: ADDR_INVALID, instr: DATA_INVALID};
    localparam ex_payload_t EX_INVALID = '{pc: ADDR_INVALID, op: OP_INVALID,
                                           rs1_val: DATA_INVALID, rs2_val: DATA_INVALID};

    // Bits needed to count 0..depth held entries.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// Entry storage for the elastic stage: one write port, one asynchronous read port.
module pipe_stage_mem
    import core_pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = 160,
    parameter int unsigned        DEPTH    = 2,
    parameter int unsigned        ADDR_W   = 1,
    parameter logic [DATA_W-1:0]  INV_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Entry array write; reset returns every entry to the invalid pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INV_DATA;
            end
        end else if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Multi-entry in-order inter-stage register with valid/ready/stall/flush.
module pipe_elastic_stage
    import core_pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = 160,
    parameter int unsigned        DEPTH    = 2,
    parameter logic [DATA_W-1:0]  INV_DATA = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            stall,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]     occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OCC_W-1:0]  occ_q, occ_n;
    logic [PTR_W-1:0]  head_q, head_n;
    logic [PTR_W-1:0]  tail_q, tail_n;
    logic              in_ready_q;
    logic              enq, deq, wen;
    logic [DATA_W-1:0] head_data;

    // Modulo-DEPTH increment by compare-and-reset (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign enq = in_valid && in_ready_q;
    assign deq = out_valid && out_ready;
    assign wen = enq && !flush;

    // Next pointer/occupancy state; flush empties the stage and drops same-cycle traffic.
    always_comb begin
        occ_n  = occ_q;
        head_n = head_q;
        tail_n = tail_q;
        if (flush) begin
            occ_n  = '0;
            head_n = '0;
            tail_n = '0;
        end else begin
            if (enq) begin
                tail_n = ptr_inc(tail_q);
            end
            if (deq) begin
                head_n = ptr_inc(head_q);
            end
            case ({enq, deq})
                2'b10:   occ_n = occ_q + OCC_W'(1);
                2'b01:   occ_n = occ_q - OCC_W'(1);
                default: occ_n = occ_q;
            endcase
        end
    end

    // Control state; in_ready is precomputed so it never sees out_ready or stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            in_ready_q <= (occ_n < OCC_W'(DEPTH));
        end
    end

    pipe_stage_mem #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (PTR_W),
        .INV_DATA (INV_DATA)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (tail_q),
        .wdata (in_data),
        .raddr (head_q),
        .rdata (head_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != '0) && !stall;
    assign out_data  = (occ_q != '0) ? head_data : INV_DATA;
    assign occupancy = occ_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                                     !(enq && occ_q == OCC_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                                     !(deq && occ_q == '0));

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage at DEPTH=1, 2 and 3.
module tb_pipe_elastic_stage;

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] INV = 16'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=2 instance
    logic fl2 = 0, st2 = 0, iv2 = 0, or2 = 0, ir2, ov2;
    logic [DW-1:0] id2 = '0, od2;
    logic [1:0] oc2;
    // DEPTH=3 instance
    logic fl3 = 0, st3 = 0, iv3 = 0, or3 = 0, ir3, ov3;
    logic [DW-1:0] id3 = '0, od3;
    logic [1:0] oc3;
    // DEPTH=1 instance
    logic fl1 = 0, st1 = 0, iv1 = 0, or1 = 0, ir1, ov1;
    logic [DW-1:0] id1 = '0, od1;
    logic [0:0] oc1;

    pipe_elastic_stage #(.DATA_W(DW), .DEPTH(2), .INV_DATA(INV)) dut2 (
        .clk(clk), .rst(rst), .flush(fl2), .stall(st2), .in_valid(iv2), .in_ready(ir2),
        .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(oc2));
    pipe_elastic_stage #(.DATA_W(DW), .DEPTH(3), .INV_DATA(INV)) dut3 (
        .clk(clk), .rst(rst), .flush(fl3), .stall(st3), .in_valid(iv3), .in_ready(ir3),
        .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(oc3));
    pipe_elastic_stage #(.DATA_W(DW), .DEPTH(1), .INV_DATA(INV)) dut1 (
        .clk(clk), .rst(rst), .flush(fl1), .stall(st1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks += 12;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b exp 0", ov2); end
        if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_ir2 got %b exp 1", ir2); end
        if (oc2 !== 2'd0) begin errors++; $display("FAIL reset_oc2 got %0d exp 0", oc2); end
        if (od2 !== INV)  begin errors++; $display("FAIL reset_od2 got %h exp %h", od2, INV); end
        if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_ov3 got %b exp 0", ov3); end
        if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_ir3 got %b exp 1", ir3); end
        if (oc3 !== 2'd0) begin errors++; $display("FAIL reset_oc3 got %0d exp 0", oc3); end
        if (od3 !== INV)  begin errors++; $display("FAIL reset_od3 got %h exp %h", od3, INV); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
        if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_ir1 got %b exp 1", ir1); end
        if (oc1 !== 1'd0) begin errors++; $display("FAIL reset_oc1 got %0d exp 0", oc1); end
        if (od1 !== INV)  begin errors++; $display("FAIL reset_od1 got %h exp %h", od1, INV); end
        tick();
    endtask

    // DEPTH=2 streaming: one transfer per cycle, occupancy stays at 1.
    task automatic test_stream();
        or2 = 1'b1;
        iv2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            id2 = DW'(k);
            #1;
            if (k == 1) begin
                checks++;
                if (ov2 !== 1'b0) begin errors++; $display("FAIL stream_first_ov got %b exp 0", ov2); end
            end else begin
                checks += 4;
                if (od2 !== DW'(k - 1)) begin errors++; $display("FAIL stream_od[%0d] got %h exp %h", k, od2, DW'(k - 1)); end
                if (ov2 !== 1'b1) begin errors++; $display("FAIL stream_ov[%0d] got %b exp 1", k, ov2); end
                if (oc2 !== 2'd1) begin errors++; $display("FAIL stream_oc[%0d] got %0d exp 1", k, oc2); end
                if (ir2 !== 1'b1) begin errors++; $display("FAIL stream_ir[%0d] got %b exp 1", k, ir2); end
            end
            tick();
        end
        iv2 = 1'b0;
        #1;
        checks++;
        if (od2 !== 16'd6) begin errors++; $display("FAIL stream_last got %h exp 0006", od2); end
        tick();
        checks += 2;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL stream_drain_ov got %b exp 0", ov2); end
        if (od2 !== INV)  begin errors++; $display("FAIL stream_drain_od got %h exp %h", od2, INV); end
        or2 = 1'b0;
    endtask

    // DEPTH=2 backpressure: A,B held, C waits upstream, then in-order drain.
    task automatic test_backpressure();
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 16'h00A1;
        tick();
        id2 = 16'h00B2;
        tick();
        id2 = 16'h00C3;
        #1;
        checks += 4;
        if (ir2 !== 1'b0) begin errors++; $display("FAIL bp_full_ir got %b exp 0", ir2); end
        if (oc2 !== 2'd2) begin errors++; $display("FAIL bp_full_oc got %0d exp 2", oc2); end
        if (od2 !== 16'h00A1) begin errors++; $display("FAIL bp_full_od got %h exp 00a1", od2); end
        if (ov2 !== 1'b1) begin errors++; $display("FAIL bp_full_ov got %b exp 1", ov2); end
        tick();
        or2 = 1'b1;
        #1;
        checks += 3;
        if (oc2 !== 2'd2) begin errors++; $display("FAIL bp_hold_oc got %0d exp 2", oc2); end
        if (ir2 !== 1'b0) begin errors++; $display("FAIL bp_deq_ir got %b exp 0", ir2); end
        if (od2 !== 16'h00A1) begin errors++; $display("FAIL bp_out_a got %h exp 00a1", od2); end
        tick();
        checks += 3;
        if (ir2 !== 1'b1) begin errors++; $display("FAIL bp_ir_back got %b exp 1", ir2); end
        if (oc2 !== 2'd1) begin errors++; $display("FAIL bp_oc_after_a got %0d exp 1", oc2); end
        if (od2 !== 16'h00B2) begin errors++; $display("FAIL bp_out_b got %h exp 00b2", od2); end
        tick();
        iv2 = 1'b0;
        #1;
        checks += 2;
        if (od2 !== 16'h00C3) begin errors++; $display("FAIL bp_out_c got %h exp 00c3", od2); end
        if (oc2 !== 2'd1) begin errors++; $display("FAIL bp_oc_c got %0d exp 1", oc2); end
        tick();
        checks += 2;
        if (oc2 !== 2'd0) begin errors++; $display("FAIL bp_empty_oc got %0d exp 0", oc2); end
        if (ov2 !== 1'b0) begin errors++; $display("FAIL bp_empty_ov got %b exp 0", ov2); end
        or2 = 1'b0;
    endtask

    // DEPTH=3 stall: no dequeue, enqueue still accepted, then FIFO drain.
    task automatic test_stall();
        or3 = 1'b0;
        iv3 = 1'b1; id3 = 16'h0011;
        tick();
        id3 = 16'h0022;
        tick();
        st3 = 1'b1; or3 = 1'b1; id3 = 16'h0033;
        #1;
        checks += 3;
        if (ov3 !== 1'b0) begin errors++; $display("FAIL stall_ov got %b exp 0", ov3); end
        if (ir3 !== 1'b1) begin errors++; $display("FAIL stall_ir got %b exp 1", ir3); end
        if (od3 !== 16'h0011) begin errors++; $display("FAIL stall_od got %h exp 0011", od3); end
        tick();
        iv3 = 1'b0;
        #1;
        checks += 3;
        if (oc3 !== 2'd3) begin errors++; $display("FAIL stall_oc3 got %0d exp 3", oc3); end
        if (ir3 !== 1'b0) begin errors++; $display("FAIL stall_full_ir got %b exp 0", ir3); end
        if (ov3 !== 1'b0) begin errors++; $display("FAIL stall_full_ov got %b exp 0", ov3); end
        tick();
        checks++;
        if (oc3 !== 2'd3) begin errors++; $display("FAIL stall_hold_oc got %0d exp 3", oc3); end
        st3 = 1'b0;
        #1;
        checks += 2;
        if (ov3 !== 1'b1) begin errors++; $display("FAIL stall_release_ov got %b exp 1", ov3); end
        if (od3 !== 16'h0011) begin errors++; $display("FAIL stall_drain0 got %h exp 0011", od3); end
        tick();
        checks += 2;
        if (od3 !== 16'h0022) begin errors++; $display("FAIL stall_drain1 got %h exp 0022", od3); end
        if (oc3 !== 2'd2) begin errors++; $display("FAIL stall_drain1_oc got %0d exp 2", oc3); end
        tick();
        checks++;
        if (od3 !== 16'h0033) begin errors++; $display("FAIL stall_drain2 got %h exp 0033", od3); end
        tick();
        checks += 2;
        if (oc3 !== 2'd0) begin errors++; $display("FAIL stall_empty_oc got %0d exp 0", oc3); end
        if (od3 !== INV)  begin errors++; $display("FAIL stall_empty_od got %h exp %h", od3, INV); end
        or3 = 1'b0;
    endtask

    // DEPTH=3 flush at occupancy 2 with coincident enq and deq.
    task automatic test_flush();
        or3 = 1'b0;
        iv3 = 1'b1; id3 = 16'h0101;
        tick();
        id3 = 16'h0202;
        tick();
        id3 = 16'h0303; or3 = 1'b1; fl3 = 1'b1;
        #1;
        checks += 2;
        if (ov3 !== 1'b1) begin errors++; $display("FAIL flush_pre_ov got %b exp 1", ov3); end
        if (ir3 !== 1'b1) begin errors++; $display("FAIL flush_pre_ir got %b exp 1", ir3); end
        tick();
        fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
        #1;
        checks += 4;
        if (oc3 !== 2'd0) begin errors++; $display("FAIL flush_oc got %0d exp 0", oc3); end
        if (ov3 !== 1'b0) begin errors++; $display("FAIL flush_ov got %b exp 0", ov3); end
        if (od3 !== INV)  begin errors++; $display("FAIL flush_od got %h exp %h", od3, INV); end
        if (ir3 !== 1'b1) begin errors++; $display("FAIL flush_ir got %b exp 1", ir3); end
        iv3 = 1'b1; id3 = 16'h0404; or3 = 1'b1;
        tick();
        iv3 = 1'b0;
        #1;
        checks += 2;
        if (od3 !== 16'h0404) begin errors++; $display("FAIL flush_next_od got %h exp 0404", od3); end
        if (oc3 !== 2'd1) begin errors++; $display("FAIL flush_next_oc got %0d exp 1", oc3); end
        tick();
        checks++;
        if (oc3 !== 2'd0) begin errors++; $display("FAIL flush_final_oc got %0d exp 0", oc3); end
        or3 = 1'b0;
    endtask

    // DEPTH=1 continuous traffic: in_ready toggles, one transfer every two cycles.
    task automatic test_depth1();
        logic [DW-1:0] next_val;
        next_val = 16'd1;
        iv1 = 1'b1; or1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            id1 = next_val;
            #1;
            checks += 3;
            if (ir1 !== ((c % 2) == 0)) begin errors++; $display("FAIL d1_ir[%0d] got %b exp %b", c, ir1, (c % 2) == 0); end
            if (ov1 !== ((c % 2) == 1)) begin errors++; $display("FAIL d1_ov[%0d] got %b exp %b", c, ov1, (c % 2) == 1); end
            if ((c % 2) == 1) begin
                if (od1 !== DW'((c + 1) / 2)) begin errors++; $display("FAIL d1_od[%0d] got %h exp %h", c, od1, DW'((c + 1) / 2)); end
            end else begin
                if (od1 !== INV) begin errors++; $display("FAIL d1_od[%0d] got %h exp %h", c, od1, INV); end
            end
            if (iv1 && ir1) next_val = next_val + 16'd1;
            tick();
        end
        iv1 = 1'b0; or1 = 1'b0;
        tick();
    endtask

    // Reset arriving with partial occupancy empties the stage in one cycle.
    task automatic test_mid_reset();
        or3 = 1'b0;
        iv3 = 1'b1; id3 = 16'h0505;
        tick();
        id3 = 16'h0606;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; iv3 = 1'b0;
        #1;
        checks += 4;
        if (oc3 !== 2'd0) begin errors++; $display("FAIL mrst_oc got %0d exp 0", oc3); end
        if (ov3 !== 1'b0) begin errors++; $display("FAIL mrst_ov got %b exp 0", ov3); end
        if (ir3 !== 1'b1) begin errors++; $display("FAIL mrst_ir got %b exp 1", ir3); end
        if (od3 !== INV)  begin errors++; $display("FAIL mrst_od got %h exp %h", od3, INV); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_flush();
        test_depth1();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
